// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: issues register-file reads, tracks outstanding writes
// in a scoreboard, stalls on RAW/WAW hazards and forwards same-cycle writeback data.
module operand_fetch_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int NREG    = 8,
  parameter int STALL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // decode side
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_rs_a,
  input  logic [ADDR_W-1:0] issue_rs_b,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_wr_en,
  // register file
  output logic [ADDR_W-1:0] rf_read_reg_a,
  output logic [ADDR_W-1:0] rf_read_reg_b,
  input  logic [DATA_W-1:0] rf_read_data_a,
  input  logic [DATA_W-1:0] rf_read_data_b,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  // writeback
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  // execute side
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_wr_en,
  // status
  output logic [STALL_W-1:0] stall_cnt,
  output logic               wb_err
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  state_t            state, state_next;
  logic [NREG-1:0]   pending, pending_next;
  logic              fwd_a, fwd_b, fwd_rd;
  logic              raw_hazard, waw_hazard;
  logic              accept;

  assign rf_read_reg_a = issue_rs_a;
  assign rf_read_reg_b = issue_rs_b;
  assign rf_write_reg  = wb_rd;
  assign rf_write_data = wb_data;
  assign rf_reg_write  = wb_valid;

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  assign fwd_a  = wb_valid && (wb_rd == issue_rs_a);
  assign fwd_b  = wb_valid && (wb_rd == issue_rs_b);
  assign fwd_rd = wb_valid && (wb_rd == issue_rd);

  assign raw_hazard = (pending[issue_rs_a] && !fwd_a) || (pending[issue_rs_b] && !fwd_b);
  assign waw_hazard = issue_wr_en && pending[issue_rd] && !fwd_rd;

  assign issue_ready = !(raw_hazard || waw_hazard) && ((state == S_EMPTY) || op_ready);
  assign accept      = issue_valid && issue_ready;
  assign op_valid    = (state == S_FULL);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      S_EMPTY: if (accept) state_next = S_FULL;
      S_FULL:  if (op_ready) state_next = accept ? S_FULL : S_EMPTY;
      default: state_next = S_EMPTY;
    endcase
    // Set is applied last so it wins over a clear of the same register.
    if (wb_valid)               pending_next[wb_rd]    = 1'b0;
    if (accept && issue_wr_en)  pending_next[issue_rd] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_EMPTY;
      pending   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_rd     <= '0;
      op_wr_en  <= 1'b0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      // Accept is only possible when the stage is empty or draining, so op_* hold otherwise.
      if (accept) begin
        op_a     <= fwd_a ? wb_data : rf_read_data_a;
        op_b     <= fwd_b ? wb_data : rf_read_data_b;
        op_rd    <= issue_rd;
        op_wr_en <= issue_wr_en;
      end
      if (issue_valid && !issue_ready && (stall_cnt != STALL_MAX))
        stall_cnt <= stall_cnt + STALL_ONE;
      if (wb_valid && !pending[wb_rd])
        wb_err <= 1'b1;
    end
  end

endmodule

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
- Requester side of the 8-entry register file: issues operand reads, drives the write port from writeback, and hands operands to execute.
- Holds an 8-bit scoreboard of outstanding destination writes. Stalls issue on RAW/WAW hazards and forwards same-cycle writeback data.
- Sits between decode (issue handshake) and execute (operand handshake), with one registered output stage.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register address width
- NREG, 8, register count (2**ADDR_W)
- STALL_W, 8, width of saturating stall counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  instruction accepted this cycle when issue_valid is also 1
- issue_rs_a  in  ADDR_W  source A register
- issue_rs_b  in  ADDR_W  source B register
- issue_rd  in  ADDR_W  destination register
- issue_wr_en  in  1  instruction will write issue_rd
- rf_read_reg_a  out  ADDR_W  register file read address A (= issue_rs_a, combinational)
- rf_read_reg_b  out  ADDR_W  register file read address B (= issue_rs_b, combinational)
- rf_read_data_a  in  DATA_W  register file read data A
- rf_read_data_b  in  DATA_W  register file read data B
- rf_write_reg  out  ADDR_W  register file write address (= wb_rd)
- rf_write_data  out  DATA_W  register file write data (= wb_data)
- rf_reg_write  out  1  register file write enable (= wb_valid)
- wb_valid  in  1  writeback present this cycle
- wb_rd  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- op_valid  out  1  operands valid to execute
- op_ready  in  1  execute accepts operands
- op_a, op_b  out  DATA_W  registered operands
- op_rd  out  ADDR_W  registered destination
- op_wr_en  out  1  registered write flag
- stall_cnt  out  STALL_W  cycles with issue_valid=1 and issue_ready=0, saturating
- wb_err  out  1  sticky: writeback to a register whose pending bit was clear

Behaviour:
- Reset (reset=0, async): op_valid=0; op_a, op_b, op_rd, op_wr_en=0; scoreboard=0; stall_cnt=0; wb_err=0; FSM=S_EMPTY. The rf_* outputs are combinational pass-throughs and are not reset.
- fwd_a = wb_valid && wb_rd==issue_rs_a. fwd_b is defined likewise for issue_rs_b.
- Hazard:
  - RAW: (pending[rs_a] && !fwd_a) || (pending[rs_b] && !fwd_b).
  - WAW: issue_wr_en && pending[rd] && !(wb_valid && wb_rd==rd).
- issue_ready = !hazard && (state==S_EMPTY || op_ready). Combinational; must not depend on issue_valid.
- Accept (issue_valid && issue_ready), effective next edge:
  - op_a <= fwd_a ? wb_data : rf_read_data_a. op_b is loaded likewise.
  - op_rd, op_wr_en are loaded; op_valid <= 1.
  - Issue-to-op_valid latency is 1 cycle.
- FSM:
  - S_EMPTY: accept -> S_FULL.
  - S_FULL: op_ready && accept -> S_FULL with new data (back-to-back, no bubble); op_ready && !accept -> S_EMPTY; !op_ready -> hold all op_* stable.
- Scoreboard, per register r, each edge:
  - Set if accept && issue_wr_en && issue_rd==r.
  - Else clear if wb_valid && wb_rd==r.
  - Set wins over a simultaneous clear of the same register.
- wb_err: set when wb_valid && !pending[wb_rd] (sampled before update). Stays set until reset. The register file write still occurs.
- stall_cnt: increments when issue_valid && !issue_ready. Saturates at 2**STALL_W-1; no wrap.
- Reset mid-operation: in-flight op and all pending bits are discarded. The register file is not touched.

Test Plan:
- Reset, then issue rs_a=1, rs_b=2, rd=3, wr_en=1, with rf returning 0x01/0x02 and op_ready=1 -> op_valid=1 next cycle, op_a=0x01, op_b=0x02, pending[3]=1.
- RAW: the rd=3 instruction is pending; issue rs_a=3, no wb -> issue_ready=0, stall_cnt increments each cycle. Then wb_valid with wb_rd=3, wb_data=0x5A in the same cycle -> accept, op_a=0x5A, pending[3] cleared.
- Backpressure: op_ready=0 for 4 cycles with the next instruction valid -> op_* held constant, issue_ready=0, stall_cnt=4. Raise op_ready -> back-to-back transfer with no bubble.
- Same-register set/clear: wb_rd=4 and an accepted issue rd=4, wr_en=1 in one cycle -> pending[4]=1 afterwards, wb_err=0.
- Spurious writeback: wb_valid, wb_rd=6 with pending[6]=0 -> rf_reg_write=1, wb_err=1 and sticky until reset.
- Assert reset low while in S_FULL with pending bits set -> immediately op_valid=0, scoreboard=0, stall_cnt=0. A following rs_a=3 issues without stall.
